// File: rtl/oc8051_arb_pkg.sv
// Shared definitions for the oc8051 instruction/data memory arbiter:
// FSM encoding, grant ids, default wait limit and byte-lane helpers.
package oc8051_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  localparam logic GID_I = 1'b0;
  localparam logic GID_D = 1'b1;

  localparam int TIMEOUT_DEF = 15;

  function automatic logic [3:0] lane_sel(input logic [1:0] a);
    case (a)
      2'd0:    lane_sel = 4'b0001;
      2'd1:    lane_sel = 4'b0010;
      2'd2:    lane_sel = 4'b0100;
      default: lane_sel = 4'b1000;
    endcase
  endfunction

  // Lane n of the memory word carries byte address n (little-endian).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] a);
    case (a)
      2'd0:    lane_byte = w[7:0];
      2'd1:    lane_byte = w[15:8];
      2'd2:    lane_byte = w[23:16];
      default: lane_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/oc8051_arb_timer.sv
// Wait counter for a granted transaction: cleared while idle, counts
// response-less grant cycles and holds once the limit is reached.
module oc8051_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_expired;

  assign w_expired = (r_cnt == CW'(TIMEOUT));
  assign o_expired = w_expired;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/oc8051_mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between the oc8051
// instruction fetch and byte-wide data Wishbone masters.
//
//   state    | meaning
//   ST_IDLE  | no transaction; arbitrate between pending requesters
//   ST_GNT_I | instruction fetch owns the memory port
//   ST_GNT_D | data access owns the memory port
module oc8051_mem_arbiter
  import oc8051_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wbi_adr_i,
  input  logic        wbi_stb_i,
  input  logic        wbi_cyc_i,
  output logic [31:0] wbi_dat_o,
  output logic        wbi_ack_o,
  output logic        wbi_err_o,
  input  logic [15:0] wbd_adr_i,
  input  logic [7:0]  wbd_dat_i,
  input  logic        wbd_we_i,
  input  logic        wbd_stb_i,
  input  logic        wbd_cyc_i,
  output logic [7:0]  wbd_dat_o,
  output logic        wbd_ack_o,
  output logic        wbd_err_o,
  output logic [15:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_stb_o,
  output logic        mem_cyc_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  input  logic        mem_err_i
);

  arb_state_t  r_state;
  logic        r_last_gnt;
  logic [1:0]  r_lane;
  logic [15:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_act;

  logic w_req_i, w_req_d, w_resp, w_expired, w_gnt_cyc, w_done;
  logic w_live_i, w_live_d, w_unused;

  assign w_req_i  = wbi_stb_i & wbi_cyc_i;
  assign w_req_d  = wbd_stb_i & wbd_cyc_i;
  assign w_resp   = mem_ack_i | mem_err_i;
  assign w_unused = ^wbi_adr_i[1:0];

  always_comb begin
    w_gnt_cyc = 1'b0;
    case (r_state)
      ST_GNT_I: w_gnt_cyc = wbi_cyc_i;
      ST_GNT_D: w_gnt_cyc = wbd_cyc_i;
      default:  w_gnt_cyc = 1'b0;
    endcase
  end

  // A dropped cyc, a memory response or the wait limit all end the grant.
  assign w_done = !w_gnt_cyc || w_resp || w_expired;

  oc8051_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_clr     (r_state == ST_IDLE),
    .i_en      ((r_state != ST_IDLE) && !w_resp),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= GID_I;
      r_lane     <= 2'd0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_act      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_d && (!w_req_i || r_last_gnt == GID_I)) begin
            r_state <= ST_GNT_D;
            r_adr   <= {wbd_adr_i[15:2], 2'b00};
            r_sel   <= lane_sel(wbd_adr_i[1:0]);
            r_dat   <= {4{wbd_dat_i}};
            r_we    <= wbd_we_i;
            r_lane  <= wbd_adr_i[1:0];
            r_act   <= 1'b1;
          end else if (w_req_i) begin
            r_state <= ST_GNT_I;
            r_adr   <= {wbi_adr_i[15:2], 2'b00};
            r_sel   <= 4'hF;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_act   <= 1'b1;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (w_done) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_act      <= 1'b0;
            r_last_gnt <= (r_state == ST_GNT_I) ? GID_I : GID_D;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_adr_o = r_adr;
  assign mem_dat_o = r_dat;
  assign mem_sel_o = r_sel;
  assign mem_we_o  = r_we;
  assign mem_stb_o = r_act;
  assign mem_cyc_o = r_act;

  // Responses are suppressed during reset so an abandoned cycle stays silent.
  assign w_live_i = (r_state == ST_GNT_I) && wbi_cyc_i && !wb_rst_i;
  assign w_live_d = (r_state == ST_GNT_D) && wbd_cyc_i && !wb_rst_i;

  assign wbi_ack_o = w_live_i && mem_ack_i && !mem_err_i;
  assign wbi_err_o = w_live_i && (mem_err_i || (w_expired && !mem_ack_i));
  assign wbd_ack_o = w_live_d && mem_ack_i && !mem_err_i;
  assign wbd_err_o = w_live_d && (mem_err_i || (w_expired && !mem_ack_i));

  assign wbi_dat_o = (r_state == ST_GNT_I) ? mem_dat_i : 32'h0;
  assign wbd_dat_o = (r_state == ST_GNT_D) ? lane_byte(mem_dat_i, r_lane) : 8'h0;

endmodule

// File: tb/tb_oc8051_mem_arbiter.sv
// Self-checking bench for oc8051_mem_arbiter: vector table with a grant
// scoreboard, plus hand sequences for ties, timeout, reset and abort.
module tb_oc8051_mem_arbiter;

  localparam int TMO = 15;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [15:0] wbi_adr_i;
  logic        wbi_stb_i, wbi_cyc_i;
  logic [31:0] wbi_dat_o;
  logic        wbi_ack_o, wbi_err_o;
  logic [15:0] wbd_adr_i;
  logic [7:0]  wbd_dat_i;
  logic        wbd_we_i, wbd_stb_i, wbd_cyc_i;
  logic [7:0]  wbd_dat_o;
  logic        wbd_ack_o, wbd_err_o;
  logic [15:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o, mem_stb_o, mem_cyc_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i, mem_err_i;

  always #5 wb_clk_i = ~wb_clk_i;

  oc8051_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbi_adr_i(wbi_adr_i), .wbi_stb_i(wbi_stb_i), .wbi_cyc_i(wbi_cyc_i),
    .wbi_dat_o(wbi_dat_o), .wbi_ack_o(wbi_ack_o), .wbi_err_o(wbi_err_o),
    .wbd_adr_i(wbd_adr_i), .wbd_dat_i(wbd_dat_i), .wbd_we_i(wbd_we_i),
    .wbd_stb_i(wbd_stb_i), .wbd_cyc_i(wbd_cyc_i),
    .wbd_dat_o(wbd_dat_o), .wbd_ack_o(wbd_ack_o), .wbd_err_o(wbd_err_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o),
    .mem_we_o (mem_we_o),  .mem_stb_o(mem_stb_o), .mem_cyc_o(mem_cyc_o),
    .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i)
  );

  typedef struct {
    logic        is_d;
    logic [15:0] adr;
    logic [7:0]  wdat;
    logic        we;
    logic [31:0] rdat;
    int          dly;
    logic        ack;
    logic        err;
    logic [15:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_mdat;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic [15:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] mdat;
    logic        is_d;
  } gnt_t;

  gnt_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wbi_adr_i = '0; wbi_stb_i = 0; wbi_cyc_i = 0;
    wbd_adr_i = '0; wbd_dat_i = '0; wbd_we_i = 0; wbd_stb_i = 0; wbd_cyc_i = 0;
    mem_dat_i = '0; mem_ack_i = 0; mem_err_i = 0;
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1;
    idle_inputs();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 0;
  endtask

  task automatic run_vec(input vec_t v);
    gnt_t e;
    @(negedge wb_clk_i);
    if (v.is_d) begin
      wbd_adr_i = v.adr; wbd_dat_i = v.wdat; wbd_we_i = v.we;
      wbd_stb_i = 1; wbd_cyc_i = 1;
    end else begin
      wbi_adr_i = v.adr; wbi_stb_i = 1; wbi_cyc_i = 1;
    end
    sb.push_back('{v.e_adr, v.e_sel, v.we, v.e_mdat, v.is_d});
    @(negedge wb_clk_i);
    check("vec_gnt_stb", mem_stb_o, 1);
    check("vec_gnt_cyc", mem_cyc_o, 1);
    e = sb.pop_front();
    check("vec_adr", mem_adr_o, e.adr);
    check("vec_sel", mem_sel_o, e.sel);
    check("vec_we", mem_we_o, e.we);
    if (e.is_d) check("vec_mdat", mem_dat_o, e.mdat);
    repeat (v.dly) begin
      check("vec_wait_ack", v.is_d ? wbd_ack_o : wbi_ack_o, 0);
      @(negedge wb_clk_i);
    end
    mem_ack_i = v.ack; mem_err_i = v.err; mem_dat_i = v.rdat;
    #1;
    if (v.is_d) begin
      check("vec_d_ack", wbd_ack_o, v.ack & ~v.err);
      check("vec_d_err", wbd_err_o, v.err);
      check("vec_d_rdat", wbd_dat_o, v.e_rd);
      check("vec_i_quiet", {wbi_ack_o, wbi_err_o}, 0);
    end else begin
      check("vec_i_ack", wbi_ack_o, v.ack & ~v.err);
      check("vec_i_err", wbi_err_o, v.err);
      check("vec_i_rdat", wbi_dat_o, v.e_rd);
      check("vec_d_quiet", {wbd_ack_o, wbd_err_o}, 0);
    end
    @(negedge wb_clk_i);
    mem_ack_i = 0; mem_err_i = 0;
    wbi_stb_i = 0; wbi_cyc_i = 0; wbd_stb_i = 0; wbd_cyc_i = 0;
    #1;
    check("vec_release_stb", mem_stb_o, 0);
    check("vec_one_cycle_ack", {wbi_ack_o, wbd_ack_o, wbi_err_o, wbd_err_o}, 0);
  endtask

  vec_t vecs[7];

  initial begin
    gnt_t e;

    vecs[0] = '{1'b0, 16'h0012, 8'h00, 1'b0, 32'h12345678, 2, 1'b1, 1'b0,
                16'h0010, 4'hF, 32'h0, 32'h12345678};
    vecs[1] = '{1'b1, 16'h0102, 8'hA5, 1'b1, 32'h00000000, 0, 1'b1, 1'b0,
                16'h0100, 4'b0100, 32'hA5A5A5A5, 32'h00};
    vecs[2] = '{1'b1, 16'h0103, 8'h00, 1'b0, 32'h11223344, 1, 1'b1, 1'b0,
                16'h0100, 4'b1000, 32'h00000000, 32'h11};
    vecs[3] = '{1'b1, 16'h0100, 8'h00, 1'b0, 32'h11223344, 0, 1'b1, 1'b0,
                16'h0100, 4'b0001, 32'h00000000, 32'h44};
    vecs[4] = '{1'b1, 16'h0101, 8'h7E, 1'b1, 32'h11223344, 3, 1'b1, 1'b1,
                16'h0100, 4'b0010, 32'h7E7E7E7E, 32'h33};
    vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b1,
                16'hFFFC, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 16'hABCE, 8'h3C, 1'b0, 32'hCAFEF00D, 1, 1'b1, 1'b0,
                16'hABCC, 4'b0100, 32'h3C3C3C3C, 32'hFE};

    wb_rst_i = 1;
    idle_inputs();
    do_reset();
    #1;
    check("rst_stb_cyc", {mem_stb_o, mem_cyc_o}, 0);
    check("rst_adr", mem_adr_o, 0);
    check("rst_sel_we", {mem_sel_o, mem_we_o}, 0);
    check("rst_mdat", mem_dat_o, 0);
    check("rst_acks", {wbi_ack_o, wbi_err_o, wbd_ack_o, wbd_err_o}, 0);
    check("rst_rdat", {wbi_dat_o, wbd_dat_o}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Tie after reset: data first, then strict alternation.
    do_reset();
    @(negedge wb_clk_i);
    wbi_adr_i = 16'h0200; wbi_stb_i = 1; wbi_cyc_i = 1;
    wbd_adr_i = 16'h0301; wbd_we_i = 0; wbd_stb_i = 1; wbd_cyc_i = 1;
    for (int g = 0; g < 2; g++) begin
      sb.push_back('{16'h0300, 4'b0010, 1'b0, 32'h0, 1'b1});
      sb.push_back('{16'h0200, 4'hF, 1'b0, 32'h0, 1'b0});
    end
    for (int g = 0; g < 4; g++) begin
      @(negedge wb_clk_i);
      check("tie_stb", mem_stb_o, 1);
      e = sb.pop_front();
      check("tie_adr", mem_adr_o, e.adr);
      check("tie_sel", mem_sel_o, e.sel);
      mem_ack_i = 1;
      #1;
      check("tie_ack_d", wbd_ack_o, e.is_d);
      check("tie_ack_i", wbi_ack_o, !e.is_d);
      @(negedge wb_clk_i);
      mem_ack_i = 0;
      check("tie_idle_gap", mem_stb_o, 0);
    end
    wbi_stb_i = 0; wbi_cyc_i = 0; wbd_stb_i = 0; wbd_cyc_i = 0;

    // Silent memory: data granted first, errs at wait limit, then fetch.
    do_reset();
    @(negedge wb_clk_i);
    wbd_adr_i = 16'h0040; wbd_we_i = 0; wbd_stb_i = 1; wbd_cyc_i = 1;
    wbi_adr_i = 16'h0080; wbi_stb_i = 1; wbi_cyc_i = 1;
    for (int k = 0; k <= TMO; k++) begin
      @(negedge wb_clk_i);
      #1;
      if (k < TMO) check("tmo_early_err", wbd_err_o, 0);
      else         check("tmo_err", wbd_err_o, 1);
    end
    check("tmo_no_ack", {wbd_ack_o, wbi_err_o, wbi_ack_o}, 0);
    wbd_stb_i = 0; wbd_cyc_i = 0;
    @(negedge wb_clk_i);
    check("tmo_idle", mem_stb_o, 0);
    check("tmo_err_one_cycle", wbd_err_o, 0);
    @(negedge wb_clk_i);
    check("tmo_next_gnt", mem_stb_o, 1);
    check("tmo_next_adr", mem_adr_o, 16'h0080);
    check("tmo_next_sel", mem_sel_o, 4'hF);
    mem_ack_i = 1; mem_dat_i = 32'h0BADF00D;
    #1;
    check("tmo_next_ack", wbi_ack_o, 1);
    check("tmo_next_rdat", wbi_dat_o, 32'h0BADF00D);
    @(negedge wb_clk_i);
    mem_ack_i = 0; wbi_stb_i = 0; wbi_cyc_i = 0;

    // Reset while granted, with an ack arriving in the same cycle.
    @(negedge wb_clk_i);
    wbi_adr_i = 16'h0444; wbi_stb_i = 1; wbi_cyc_i = 1;
    @(negedge wb_clk_i);
    check("rstmid_gnt", mem_stb_o, 1);
    wb_rst_i = 1; mem_ack_i = 1;
    #1;
    check("rstmid_no_ack", {wbi_ack_o, wbi_err_o}, 0);
    @(negedge wb_clk_i);
    check("rstmid_stb_cyc", {mem_stb_o, mem_cyc_o}, 0);
    check("rstmid_adr_sel", {mem_adr_o, mem_sel_o}, 0);
    check("rstmid_acks", {wbi_ack_o, wbi_err_o, wbd_ack_o, wbd_err_o}, 0);
    wb_rst_i = 0; mem_ack_i = 0; wbi_stb_i = 0; wbi_cyc_i = 0;

    // Granted data master drops cyc: transaction abandoned without response.
    @(negedge wb_clk_i);
    wbd_adr_i = 16'h0010; wbd_dat_i = 8'h5A; wbd_we_i = 1; wbd_stb_i = 1; wbd_cyc_i = 1;
    @(negedge wb_clk_i);
    check("abort_gnt", mem_stb_o, 1);
    wbd_stb_i = 0; wbd_cyc_i = 0; mem_ack_i = 1;
    #1;
    check("abort_no_resp", {wbd_ack_o, wbd_err_o}, 0);
    @(negedge wb_clk_i);
    mem_ack_i = 0;
    check("abort_idle", mem_stb_o, 0);

    repeat (2) @(negedge wb_clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oc8051_mem_arbiter.md
OC8051_MEM_ARBITER -- requirements
Module: oc8051_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles a granted transaction waits for mem_ack_i/mem_err_i before a local error.
REQ-002 wb_clk_i  in  1  single clock, all state on rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 wbi_adr_i  in  16  instruction byte address; wbi_stb_i, wbi_cyc_i  in  1  instruction strobe/cycle.
REQ-005 wbi_dat_o  out  32  fetched word; wbi_ack_o, wbi_err_o  out  1  instruction ack/error.
REQ-006 wbd_adr_i  in  16  data byte address; wbd_dat_i  in  8  write data; wbd_we_i, wbd_stb_i, wbd_cyc_i  in  1  data write-enable/strobe/cycle.
REQ-007 wbd_dat_o  out  8  read byte; wbd_ack_o, wbd_err_o  out  1  data ack/error.
REQ-008 mem_adr_o  out  16  word-aligned address (bits 1:0 = 0); mem_dat_o  out  32  write data; mem_sel_o  out  4  byte lanes.
REQ-009 mem_we_o, mem_stb_o, mem_cyc_o  out  1  shared-memory master controls.
REQ-010 mem_dat_i  in  32  read data; mem_ack_i, mem_err_i  in  1  memory ack/error.

Function
REQ-011 FSM states SHALL be IDLE, GNT_I, GNT_D.
REQ-012 In IDLE with exactly one requester (stb&cyc) active, FSM SHALL enter that requester's grant state at next edge.
REQ-013 In IDLE with both active, grant SHALL go to the requester not served last (round-robin pointer last_gnt).
REQ-014 mem_adr_o/mem_we_o/mem_sel_o/mem_dat_o/mem_stb_o/mem_cyc_o SHALL be registered, valid from the first grant cycle (one cycle after request seen in IDLE).
REQ-015 GNT_I: mem_sel_o=4'hF, mem_we_o=0, mem_adr_o={wbi_adr_i[15:2],2'b00}; wbi_dat_o=mem_dat_i.
REQ-016 GNT_D: mem_adr_o={wbd_adr_i[15:2],2'b00}, mem_sel_o=one-hot of wbd_adr_i[1:0], mem_dat_o={4{wbd_dat_i}}, mem_we_o=wbd_we_i; wbd_dat_o=byte of mem_dat_i selected by latched adr[1:0].
REQ-017 Acks/errors SHALL pass combinationally to the granted requester only; the non-granted requester's ack/err SHALL be 0.
REQ-018 On mem_ack_i or mem_err_i, FSM SHALL return to IDLE next edge, deassert mem_stb_o/mem_cyc_o, update last_gnt.
REQ-019 mem_ack_i and mem_err_i together: deliver err only.
REQ-020 Wait counter SHALL clear on grant, increment each grant cycle without ack/err; at count==TIMEOUT assert requester err for one cycle and return IDLE; ack in that same cycle wins.
REQ-021 Granted requester dropping cyc before ack: abort, no ack/err delivered, IDLE next edge, last_gnt updated.
REQ-022 Requester may re-request the cycle after its ack; it SHALL be arbitrated normally in IDLE (min 1 idle cycle between transactions).

Reset
REQ-023 On wb_rst_i at a rising edge: FSM=IDLE, last_gnt=I (data wins first tie), counter=0, all mem_* outputs 0, all acks/errs 0, wbi_dat_o=0, wbd_dat_o=0; reset mid-transaction abandons it silently.

Structure
REQ-024 Shared package oc8051_arb_pkg SHALL hold the FSM state encoding, grant-id constants and TIMEOUT default.
REQ-025 Sub-module oc8051_arb_timer SHALL implement the wait counter (clear, enable, expired).

Verification
REQ-026 Fetch 0x0012, mem acks 2 cycles later with 0x12345678 -> mem_adr_o 0x0010, mem_sel_o F, wbi_dat_o 0x12345678, one-cycle wbi_ack_o.
REQ-027 Data write 0x0102 data A5 -> mem_adr_o 0x0100, mem_sel_o 0100, mem_dat_o A5A5A5A5, mem_we_o 1; data read 0x0103, mem_dat_i 11223344 -> wbd_dat_o 11.
REQ-028 Both request simultaneously after reset -> data served first, then instruction; alternation continues on repeated ties.
REQ-029 Memory never responds -> requester err exactly at 15th wait cycle, IDLE next edge, other requester then granted.
REQ-030 wb_rst_i mid-grant -> all outputs 0 next edge, no ack/err delivered; mem_ack_i+mem_err_i same cycle -> err only.
